// File: rtl/usb_buffer_ctrl_pkg.sv
// Shared constants and FSM state type for the USB buffer controller.
// Buffer geometry is fixed; occupancy is wide enough to hold the value DEPTH itself.
package usb_buf_pkg;

   localparam int DEPTH = 64;
   localparam int OCC_W = $clog2(DEPTH + 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      TX_FILL  = 3'd1,
      TX_SEND  = 3'd2,
      RX_FILL  = 3'd3,
      RX_DRAIN = 3'd4
   } state_t;

endpackage

// File: rtl/usb_buffer_ctrl_if.sv
// Signal bundle between the buffer controller and its surroundings
// (host interface, TX/RX packet engines and the buffer itself).
interface usb_buffer_ctrl_if;
   import usb_buf_pkg::*;

   logic             host_wr_req;
   logic             host_rd_req;
   logic             host_ack;
   logic             host_rd_valid;
   logic             host_clear;
   logic             tx_commit;
   logic             usb_wr_req;
   logic             usb_rd_req;
   logic             usb_ack;
   logic             rx_done;
   logic             rx_abort;
   logic [OCC_W-1:0] buffer_occupancy;
   logic             store_tx_data;
   logic             store_rx_packet_data;
   logic             get_tx_packet_data;
   logic             get_rx_data;
   logic             flush;
   logic             clear;
   logic             tx_ready;
   logic [OCC_W-1:0] tx_len;
   logic             rx_avail;
   logic             err_ovf;
   logic             err_udf;

   // Controller side
   modport slave (
      input  host_wr_req, host_rd_req, host_clear, tx_commit,
      input  usb_wr_req, usb_rd_req, rx_done, rx_abort, buffer_occupancy,
      output host_ack, host_rd_valid, usb_ack,
      output store_tx_data, store_rx_packet_data, get_tx_packet_data, get_rx_data,
      output flush, clear, tx_ready, tx_len, rx_avail, err_ovf, err_udf
   );

   // Environment side: requesters plus the buffer
   modport master (
      output host_wr_req, host_rd_req, host_clear, tx_commit,
      output usb_wr_req, usb_rd_req, rx_done, rx_abort, buffer_occupancy,
      input  host_ack, host_rd_valid, usb_ack,
      input  store_tx_data, store_rx_packet_data, get_tx_packet_data, get_rx_data,
      input  flush, clear, tx_ready, tx_len, rx_avail, err_ovf, err_udf
   );

endinterface

// File: rtl/usb_buffer_ctrl.sv
// Owner of the shared USB data buffer: one transfer direction at a time,
// Mealy strobes/acks, registered tx_len and host_rd_valid.
module usb_buffer_ctrl
   import usb_buf_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   usb_buffer_ctrl_if.slave  bus
);

   state_t           state_reg;
   state_t           state_next;
   logic [OCC_W-1:0] tx_len_reg;
   logic             rd_valid_reg;
   logic             latch_len;
   logic             full;
   logic             empty;

   logic host_ack_c, usb_ack_c;
   logic store_tx_c, store_rx_c, get_tx_c, get_rx_c;
   logic flush_c, clear_c, tx_ready_c, rx_avail_c, err_ovf_c, err_udf_c;

   // Occupancy trails the strobes by exactly one cycle, so these are exact.
   assign full  = (bus.buffer_occupancy == OCC_W'(DEPTH));
   assign empty = (bus.buffer_occupancy == '0);

   always_comb begin
      host_ack_c = 1'b0;
      usb_ack_c  = 1'b0;
      store_tx_c = 1'b0;
      store_rx_c = 1'b0;
      get_tx_c   = 1'b0;
      get_rx_c   = 1'b0;
      flush_c    = 1'b0;
      clear_c    = 1'b0;
      tx_ready_c = 1'b0;
      rx_avail_c = 1'b0;
      err_ovf_c  = 1'b0;
      err_udf_c  = 1'b0;
      latch_len  = 1'b0;
      state_next = state_reg;

      if (!rst) begin
         tx_ready_c = (state_reg == TX_SEND);
         rx_avail_c = (state_reg == RX_DRAIN);

         if (bus.host_clear) begin
            clear_c    = 1'b1;
            state_next = IDLE;
         end else if (bus.rx_abort && (state_reg == RX_FILL || state_reg == RX_DRAIN)) begin
            flush_c    = 1'b1;
            state_next = IDLE;
         end else begin
            case (state_reg)
               IDLE: begin
                  // The USB side wins a tie: a packet on the wire cannot wait.
                  if (bus.usb_wr_req) begin
                     store_rx_c = 1'b1;
                     usb_ack_c  = 1'b1;
                     state_next = RX_FILL;
                  end else if (bus.host_wr_req) begin
                     store_tx_c = 1'b1;
                     host_ack_c = 1'b1;
                     state_next = TX_FILL;
                  end
               end

               TX_FILL: begin
                  if (bus.tx_commit) begin
                     if (empty) begin
                        state_next = IDLE;
                     end else begin
                        latch_len  = 1'b1;
                        state_next = TX_SEND;
                     end
                  end else if (bus.host_wr_req) begin
                     if (full) begin
                        err_ovf_c = 1'b1;
                     end else begin
                        store_tx_c = 1'b1;
                        host_ack_c = 1'b1;
                     end
                  end
               end

               TX_SEND: begin
                  if (empty) begin
                     err_udf_c  = bus.usb_rd_req;
                     state_next = IDLE;
                  end else if (bus.usb_rd_req) begin
                     get_tx_c  = 1'b1;
                     usb_ack_c = 1'b1;
                  end
               end

               RX_FILL: begin
                  // End of packet takes the cycle; a trailing write is not stored.
                  if (bus.rx_done) begin
                     state_next = empty ? IDLE : RX_DRAIN;
                  end else if (bus.usb_wr_req) begin
                     if (full) begin
                        err_ovf_c = 1'b1;
                     end else begin
                        store_rx_c = 1'b1;
                        usb_ack_c  = 1'b1;
                     end
                  end
               end

               RX_DRAIN: begin
                  if (empty) begin
                     err_udf_c  = bus.host_rd_req;
                     state_next = IDLE;
                  end else if (bus.host_rd_req) begin
                     get_rx_c   = 1'b1;
                     host_ack_c = 1'b1;
                  end
               end

               default: state_next = IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         tx_len_reg   <= '0;
         rd_valid_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         rd_valid_reg <= get_rx_c;
         if (latch_len) begin
            tx_len_reg <= bus.buffer_occupancy;
         end
      end
   end

   assign bus.host_ack             = host_ack_c;
   assign bus.usb_ack              = usb_ack_c;
   assign bus.store_tx_data        = store_tx_c;
   assign bus.store_rx_packet_data = store_rx_c;
   assign bus.get_tx_packet_data   = get_tx_c;
   assign bus.get_rx_data          = get_rx_c;
   assign bus.flush                = flush_c;
   assign bus.clear                = clear_c;
   assign bus.tx_ready             = tx_ready_c;
   assign bus.rx_avail             = rx_avail_c;
   assign bus.err_ovf              = err_ovf_c;
   assign bus.err_udf              = err_udf_c;
   assign bus.tx_len               = tx_len_reg;
   assign bus.host_rd_valid        = rd_valid_reg;

   // The buffer accepts at most one store and one get per cycle.
   a_one_store: assert property (@(posedge clk) !(store_tx_c && store_rx_c));
   a_one_get:   assert property (@(posedge clk) !(get_tx_c && get_rx_c));

endmodule
